bsg_counter_window_ctrl: RTL and testbench
==========================================

Name: bsg_counter_window_ctrl

Overview:
- Sequences one `bsg_counter_clear_up` instance to count `event_i` pulses over a programmable window of N cycles.
- Presents the final count to a consumer with a valid/yumi handshake.
- Sits between event sources (stall, miss or hit strobes) and a perf-monitor or CSR reader that needs windowed event rates.

Parameters:
- width_p, 31, counter and result width in bits.
- len_width_p, 16, width of the window-length field.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- reset_n_i  input  1  synchronous, active-low reset.
- start_v_i  input  1  request to start a window.
- window_len_i  input  len_width_p  window length N in cycles; sampled on accept.
- ready_o  output  1  controller can accept a start.
- event_i  input  1  event strobe; counted only inside the window.
- busy_o  output  1  window in progress.
- count_v_o  output  1  result valid.
- count_o  output  width_p  event count; meaningful only when count_v_o=1.
- count_yumi_i  input  1  consumer takes the result; legal only when count_v_o=1.

Behaviour:
- Reset (reset_n_i=0 at a clock edge): FSM=IDLE, internal counter=0, ready_o=1, busy_o=0, count_v_o=0, count_o=0. The counter sub-module's reset_i is driven by ~reset_n_i.
- FSM states: IDLE, COUNT, DONE. Outputs decode from state:
  - ready_o = (state==IDLE)
  - busy_o = (state==COUNT)
  - count_v_o = (state==DONE)
- IDLE:
  - Accept = start_v_i & ready_o.
  - On accept at cycle t: latch window_len_i into len_r, assert counter clear_i in cycle t (counter=0 at t+1), load remaining=len_r.
  - N>0 -> COUNT. N==0 -> DONE with count_o=0 at t+1.
- COUNT:
  - Counter up_i = event_i.
  - Remaining decrements each cycle; the cycle in which remaining==1 is the last counted cycle, then -> DONE.
  - Exactly N cycles (t+1..t+N) are sampled. count_v_o rises at t+N+1; latency from accept to valid is N+1 cycles.
- DONE:
  - up_i=0; count_o holds.
  - Stays until count_yumi_i=1, then -> IDLE on the next edge.
  - A start cannot be accepted in DONE. The earliest next accept is the cycle after yumi.
- Outside COUNT: event_i is ignored (up_i gated to 0). start_v_i is ignored while not IDLE and is not queued.
- event_i is sampled in the same cycle as the counter; no input register stage.
- Arithmetic: count wraps modulo 2^width_p (all-ones + 1 -> 0) unless the optional feature is enabled. N is unsigned, maximum 2^len_width_p-1.
- Reset mid-window or mid-DONE: abandon the window, discard the result, return to reset values next cycle. Reset dominates start and yumi in the same cycle.
- count_yumi_i while count_v_o=0 is illegal. The bench asserts on it; the RTL ignores it.

Optional Feature:
- Macro: BSG_COUNTER_WINDOW_CTRL_SATURATE_EN.
- Defined:
  - up_i is gated off when count_o is all-ones, so the count saturates at 2^width_p-1.
  - Adds output port `sat_o` (1 bit), which mirrors (count_o==all-ones) while count_v_o=1 and is 0 otherwise. Reset value 0.
- Undefined: the count wraps and no `sat_o` port exists.

Decomposition:
- Shared package `bsg_counter_window_pkg`:
  - State enum `bsg_counter_window_state_e` {IDLE=2'b00, COUNT=2'b01, DONE=2'b10}, encoding fixed for waveform/CSR debug.
  - Default width constants.
- Sub-module: reuse existing `bsg_counter_clear_up` (width_p bits) as the counting datapath, driven by clear_i and up_i from the FSM.
- Window-remaining decrementer and FSM stay in this module.

Test Plan:
- Reset then start N=8, event_i=1 every cycle -> count_v_o rises 9 cycles after accept, count_o=8; yumi -> ready_o=1 next cycle.
- Start N=10, event_i high on cycles t+2, t+5, t+10, plus pulses at t and t+11 (outside window) -> count_o=3.
- Start N=0 -> count_v_o=1 at t+1 with count_o=0. Hold yumi low 5 cycles -> count_o stable; start_v_i pulses during DONE are not accepted.
- Start N=20, reset_n_i=0 at t+7 -> next cycle busy_o=0, count_v_o=0, count_o=0, ready_o=1. A new start N=2 with events every cycle -> count_o=2.
- Back-to-back windows: yumi and start_v_i held high continuously, N=4, 3 events per window -> each result=3. Exactly one idle cycle between DONE and the next COUNT. The second window's count does not inherit the first.
- width_p=4, N=20, event every cycle:
  - macro off -> count_o=4 (20 mod 16).
  - macro on -> count_o=15, sat_o=1.

Source files
------------

// File: rtl/bsg_counter_window_pkg.sv
// bsg_counter_window_pkg
// Shared definitions for the windowed event counter controller.
//   - bsg_counter_window_state_e : controller FSM state, encoding fixed so that
//     waveform viewers and CSR debug reads decode the same way every build.
//   - default_width_lp / default_len_width_lp : default counter and
//     window-length widths used as parameter defaults by the RTL.
package bsg_counter_window_pkg;

  localparam int unsigned default_width_lp     = 31;
  localparam int unsigned default_len_width_lp = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } bsg_counter_window_state_e;

endpackage

// File: rtl/bsg_counter_clear_up.sv
// bsg_counter_clear_up
// Up counter with a synchronous clear; the counting datapath of the window
// controller.
// Ports:
//   clk_i    : clock, rising edge
//   reset_i  : synchronous active-high reset, count -> 0
//   clear_i  : zero the count (an up_i in the same cycle counts from zero)
//   up_i     : increment by one this cycle
//   count_o  : current count, wraps modulo 2^width_p
module bsg_counter_clear_up
  import bsg_counter_window_pkg::*;
#(
  parameter int width_p = default_width_lp
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] count_q, count_d;

  // Clear first, then add the increment, so clear+up in one cycle gives 1.
  always_comb begin
    count_d = clear_i ? '0 : count_q;
    if (up_i) begin
      count_d = count_d + width_p'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_counter_window_ctrl.sv
// bsg_counter_window_ctrl
// Counts event_i pulses over a programmable window of N cycles and hands the
// final count to a consumer through a valid/yumi handshake.
// Optional feature macro: BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
//   defined   -> count saturates at all-ones and port sat_o is present
//   undefined -> count wraps modulo 2^width_p, no sat_o port
// Ports:
//   clk_i         : clock, rising edge
//   reset_n_i     : synchronous active-low reset
//   start_v_i     : request to start a window (accepted only while ready_o)
//   window_len_i  : window length N, sampled on accept
//   ready_o       : controller is idle and can accept a start
//   event_i       : event strobe, counted only while busy_o
//   busy_o        : window in progress
//   count_v_o     : result valid
//   count_o       : event count, meaningful while count_v_o
//   count_yumi_i  : consumer takes the result
//   sat_o         : (macro only) result is saturated
module bsg_counter_window_ctrl
  import bsg_counter_window_pkg::*;
#(
  parameter int width_p     = default_width_lp,
  parameter int len_width_p = default_len_width_lp
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   start_v_i,
  input  logic [len_width_p-1:0] window_len_i,
  output logic                   ready_o,
  input  logic                   event_i,
  output logic                   busy_o,
  output logic                   count_v_o,
  output logic [width_p-1:0]     count_o,
  input  logic                   count_yumi_i
`ifdef BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
  ,
  output logic                   sat_o
`endif
);

  bsg_counter_window_state_e state_q, state_d;
  logic [len_width_p-1:0]    remaining_q, remaining_d;
  logic                      clear_li;
  logic                      up_li;
  logic                      count_at_max;

  // When saturating, an all-ones count blocks further increments; otherwise
  // the counter is free to wrap.
`ifdef BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
  assign count_at_max = &count_o;
  assign sat_o        = (state_q == DONE) & count_at_max;
`else
  assign count_at_max = 1'b0;
`endif

  // Next-state logic. The counter is cleared in the accept cycle so the
  // first counted cycle starts from zero; remaining==1 marks the last
  // counted cycle, which gives exactly N sampled cycles before DONE.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    clear_li    = 1'b0;
    up_li       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_v_i) begin
          clear_li    = 1'b1;
          remaining_d = window_len_i;
          state_d     = (window_len_i == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        up_li       = event_i & ~count_at_max;
        remaining_d = remaining_q - len_width_p'(1);
        if (remaining_q == len_width_p'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (count_yumi_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and window-remaining registers; reset abandons any window.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  bsg_counter_clear_up #(
    .width_p(width_p)
  ) counter (
    .clk_i   (clk_i),
    .reset_i (~reset_n_i),
    .clear_i (clear_li),
    .up_i    (up_li),
    .count_o (count_o)
  );

  assign ready_o   = (state_q == IDLE);
  assign busy_o    = (state_q == COUNT);
  assign count_v_o = (state_q == DONE);

endmodule

// File: tb/tb_bsg_counter_window_ctrl.sv
// tb_bsg_counter_window_ctrl
// Directed self-checking bench for bsg_counter_window_ctrl. A second instance
// with width_p=4 exercises wrap / saturation (BSG_COUNTER_WINDOW_CTRL_SATURATE_EN).
module tb_bsg_counter_window_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_v;
  logic [15:0] window_len;
  logic        ready;
  logic        event_s;
  logic        busy;
  logic        count_v;
  logic [30:0] count;
  logic        yumi;

  logic        start4;
  logic [15:0] len4;
  logic        ready4;
  logic        event4;
  logic        busy4;
  logic        count_v4;
  logic [3:0]  count4;
  logic        yumi4;
`ifdef BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
  logic        sat;
  logic        sat4;
`endif

  int checks   = 0;
  int failures = 0;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  bsg_counter_window_ctrl dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_v_i    (start_v),
    .window_len_i (window_len),
    .ready_o      (ready),
    .event_i      (event_s),
    .busy_o       (busy),
    .count_v_o    (count_v),
    .count_o      (count),
    .count_yumi_i (yumi)
`ifdef BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
    ,
    .sat_o        (sat)
`endif
  );

  bsg_counter_window_ctrl #(
    .width_p     (4),
    .len_width_p (16)
  ) dut4 (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .start_v_i    (start4),
    .window_len_i (len4),
    .ready_o      (ready4),
    .event_i      (event4),
    .busy_o       (busy4),
    .count_v_o    (count_v4),
    .count_o      (count4),
    .count_yumi_i (yumi4)
`ifdef BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
    ,
    .sat_o        (sat4)
`endif
  );

  // Advance n clock edges, leaving the bench 1 unit after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive all main-DUT inputs at once.
  task automatic applyStimulus(input logic rn, input logic st, input logic [15:0] len,
                               input logic ev, input logic ym);
    reset_n    = rn;
    start_v    = st;
    window_len = len;
    event_s    = ev;
    yumi       = ym;
  endtask

  // One counted comparison.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // A yumi while no result is valid is a protocol violation by the bench.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && yumi === 1'b1 && count_v !== 1'b1) begin
      failures++;
      $error("[TB] FAIL yumi_illegal observed count_v=%b expected 1", count_v);
    end
  end

  initial begin
    applyStimulus(1'b0, 1'b0, 16'd0, 1'b0, 1'b0);
    start4 = 1'b0;
    len4   = 16'd20;
    event4 = 1'b0;
    yumi4  = 1'b0;
    tick(2);

    // Reset values.
    checkOutput("rst_ready", 32'(ready), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_count_v", 32'(count_v), 32'd0);
    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_count4", 32'(count4), 32'd0);
`ifdef BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
    checkOutput("rst_sat", 32'(sat), 32'd0);
`endif
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1);

    // N=8, event every cycle: valid 9 cycles after accept, count 8.
    applyStimulus(1'b1, 1'b1, 16'd8, 1'b1, 1'b0);
    tick(1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    tick(7);
    checkOutput("t1_not_valid_yet", 32'(count_v), 32'd0);
    tick(1);
    checkOutput("t1_count_v", 32'(count_v), 32'd1);
    checkOutput("t1_count", 32'(count), 32'd8);
    checkOutput("t1_ready_in_done", 32'(ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    tick(1);
    checkOutput("t1_ready_after_yumi", 32'(ready), 32'd1);
    checkOutput("t1_v_after_yumi", 32'(count_v), 32'd0);

    // N=10, events at t+2,t+5,t+10 inside; t and t+11 outside -> 3.
    applyStimulus(1'b1, 1'b1, 16'd10, 1'b1, 1'b0);
    tick(1);
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b1, 1'b0, 16'd0, (k == 2 || k == 5 || k == 10 || k == 11), 1'b0);
      tick(1);
    end
    checkOutput("t2_count_v", 32'(count_v), 32'd1);
    checkOutput("t2_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    tick(1);

    // N=0: valid next cycle with 0; DONE holds and ignores starts.
    applyStimulus(1'b1, 1'b1, 16'd0, 1'b1, 1'b0);
    tick(1);
    checkOutput("t3_count_v", 32'(count_v), 32'd1);
    checkOutput("t3_count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (i % 2 == 0), 16'd5, 1'b1, 1'b0);
      tick(1);
      checkOutput("t3_hold_v", 32'(count_v), 32'd1);
      checkOutput("t3_hold_count", 32'(count), 32'd0);
      checkOutput("t3_hold_ready", 32'(ready), 32'd0);
    end
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    tick(1);
    checkOutput("t3_ready_after_yumi", 32'(ready), 32'd1);

    // N=20 interrupted by reset at t+7 (with start and yumi also high).
    applyStimulus(1'b1, 1'b1, 16'd20, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    tick(6);
    checkOutput("t4_mid_busy", 32'(busy), 32'd1);
    checkOutput("t4_mid_count", 32'(count), 32'd6);
    applyStimulus(1'b0, 1'b1, 16'd20, 1'b1, 1'b1);
    tick(1);
    checkOutput("t4_rst_busy", 32'(busy), 32'd0);
    checkOutput("t4_rst_count_v", 32'(count_v), 32'd0);
    checkOutput("t4_rst_count", 32'(count), 32'd0);
    checkOutput("t4_rst_ready", 32'(ready), 32'd1);
    applyStimulus(1'b1, 1'b1, 16'd2, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b1, 1'b0);
    tick(2);
    checkOutput("t4_new_count_v", 32'(count_v), 32'd1);
    checkOutput("t4_new_count", 32'(count), 32'd2);
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b1);
    tick(1);

    // Back-to-back N=4 windows, start held high, 3 events each.
    for (int w = 0; w < 2; w++) begin
      applyStimulus(1'b1, 1'b1, 16'd4, 1'b0, 1'b0);
      checkOutput("t5_idle_ready", 32'(ready), 32'd1);
      tick(1);
      checkOutput("t5_busy", 32'(busy), 32'd1);
      checkOutput("t5_cleared", 32'(count), 32'd0);
      for (int c = 0; c < 4; c++) begin
        applyStimulus(1'b1, 1'b1, 16'd4, (c < 3), 1'b0);
        tick(1);
      end
      checkOutput("t5_count_v", 32'(count_v), 32'd1);
      checkOutput("t5_count", 32'(count), 32'd3);
      applyStimulus(1'b1, 1'b1, 16'd4, 1'b0, 1'b1);
      tick(1);
      checkOutput("t5_one_idle", 32'(ready), 32'd1);
    end
    applyStimulus(1'b1, 1'b0, 16'd0, 1'b0, 1'b0);
    tick(1);

    // width_p=4, N=20, event every cycle: wraps to 4 or saturates at 15.
    start4 = 1'b1;
    event4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(20);
    checkOutput("t6_count_v4", 32'(count_v4), 32'd1);
`ifdef BSG_COUNTER_WINDOW_CTRL_SATURATE_EN
    checkOutput("t6_count4_sat", 32'(count4), 32'd15);
    checkOutput("t6_sat4", 32'(sat4), 32'd1);
`else
    checkOutput("t6_count4_wrap", 32'(count4), 32'd4);
`endif
    event4 = 1'b0;
    yumi4  = 1'b1;
    tick(1);
    yumi4  = 1'b0;
    checkOutput("t6_ready4", 32'(ready4), 32'd1);
    checkOutput("t6_busy4", 32'(busy4), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
